// File: rtl/brick_pkg.sv
// rtl/brick_pkg.sv - shared constants, types and helpers for the brick field store
//
// Contents:
//   DEF_ROWS / DEF_COLS  default field geometry
//   game_state_e         state manager encodings (ST_LOAD..ST_FLY)
//   count_width()        width of a brick counter for a given geometry
//   BASE_ROWS            populated rows at level 0
//   row_pat_e            kind of row pattern a level produces
//   populated_rows()     number of populated rows for a level
package brick_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 16;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_INIT = 3'd1,
    ST_WAIT = 3'd2,
    ST_FLY  = 3'd3
  } game_state_e;

  // Counter must hold every cell being a brick, hence the +1.
  function automatic int count_width(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

  localparam int DEF_CNT_W = count_width(DEF_ROWS, DEF_COLS);

  // Level 0 populates this many rows; each level adds one more.
  localparam int BASE_ROWS = 2;

  typedef enum logic {
    PAT_FULL    = 1'b0,  // even level: solid rows
    PAT_CHECKER = 1'b1   // odd level: bricks where (row+col) is even
  } row_pat_e;

  function automatic int populated_rows(input logic [2:0] level, input int rows);
    int depth;
    depth = BASE_ROWS + int'(level);
    return (depth < rows) ? depth : rows;
  endfunction

endpackage

// File: rtl/brick_field_if.sv
// rtl/brick_field_if.sv - signal bundle between the brick field and its neighbours
//
// master: state manager / ball engine / renderer side (drives state, level,
//         queries and display address).
// slave:  brick_field side (drives hit response, display data, busy, count, win).
//   state    3            game state (0 load, 1 init, 2 wait, 3 fly)
//   level    3            current level
//   q_valid  1            collision query strobe
//   q_row    $clog2(ROWS) query row
//   q_col    $clog2(COLS) query column
//   hit_valid/hit         query response
//   d_row/d_col/d_brick   display read port
//   busy     1            pattern load in progress
//   count    cnt width    bricks remaining
//   win      1            field cleared
interface brick_field_if
  import brick_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int NW = count_width(ROWS, COLS);

  logic [2:0]    state;
  logic [2:0]    level;
  logic          q_valid;
  logic [RW-1:0] q_row;
  logic [CW-1:0] q_col;
  logic          hit_valid;
  logic          hit;
  logic [RW-1:0] d_row;
  logic [CW-1:0] d_col;
  logic          d_brick;
  logic          busy;
  logic [NW-1:0] count;
  logic          win;

  modport master (
    output state, level, q_valid, q_row, q_col, d_row, d_col,
    input  hit_valid, hit, d_brick, busy, count, win
  );

  modport slave (
    input  state, level, q_valid, q_row, q_col, d_row, d_col,
    output hit_valid, hit, d_brick, busy, count, win
  );

endinterface

// File: rtl/brick_pattern.sv
// rtl/brick_pattern.sv - combinational brick pattern for one row of a level
//
// Ports:
//   i_level    in  3            current level
//   i_row      in  $clog2(ROWS) row being generated
//   o_pattern  out COLS         brick bits for that row, bit c = column c
module brick_pattern
  import brick_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic [2:0]      i_level,
  input  logic [RW-1:0]   i_row,
  output logic [COLS-1:0] o_pattern
);

  row_pat_e w_kind;
  logic     w_populated;

  assign w_kind      = i_level[0] ? PAT_CHECKER : PAT_FULL;
  assign w_populated = int'(i_row) < populated_rows(i_level, ROWS);

  always_comb begin
    o_pattern = '0;
    if (w_populated) begin
      for (int c = 0; c < COLS; c++) begin
        if (w_kind == PAT_FULL) begin
          o_pattern[c] = 1'b1;
        end else begin
          o_pattern[c] = ((int'(i_row) + c) % 2) == 0;
        end
      end
    end
  end

endmodule

// File: rtl/brick_field.sv
// rtl/brick_field.sv - brick map store: level load, collision queries, win detect
//
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-low reset
//   bus   brick_field_if.slave (see rtl/brick_field_if.sv)
//
// Optional feature: BRICK_HARD_EN - row 0 bricks take two hits; a per-cell
// hit-point bit is kept and the first hit only consumes it.
module brick_field
  import brick_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic         clk,
  input  logic         rst,
  brick_field_if.slave bus
);

  localparam int RW = $clog2(ROWS);
  localparam int NW = count_width(ROWS, COLS);

  logic [ROWS-1:0][COLS-1:0] r_field;
  logic [RW-1:0]             r_ptr;
  logic                      r_busy;
  logic [NW-1:0]             r_count;
  logic                      r_win;
  logic                      r_hit_valid;
  logic                      r_hit;
  logic                      r_d_brick;

  logic [COLS-1:0] w_pattern;
  logic [NW-1:0]   w_row_pop;
  logic            w_load_start;
  logic            w_q_ok;
  logic            w_cell;
  logic            w_clear;

  brick_pattern #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_pattern (
    .i_level   (bus.level),
    .i_row     (r_ptr),
    .o_pattern (w_pattern)
  );

  always_comb begin
    w_row_pop = '0;
    for (int c = 0; c < COLS; c++) begin
      w_row_pop = w_row_pop + NW'(w_pattern[c]);
    end
  end

  assign w_load_start = (bus.state == ST_INIT);
  // A query landing on the load-start edge is treated like one during busy:
  // the field is about to be overwritten, so it must not score.
  assign w_q_ok = bus.q_valid & ~r_busy & ~w_load_start;
  assign w_cell = r_field[bus.q_row][bus.q_col];

`ifdef BRICK_HARD_EN
  logic [ROWS-1:0][COLS-1:0] r_hp;
  logic                      w_hp;
  logic                      w_soften;

  assign w_hp     = r_hp[bus.q_row][bus.q_col];
  assign w_clear  = w_q_ok & w_cell & ~w_hp;
  assign w_soften = w_q_ok & w_cell & w_hp;
`else
  assign w_clear = w_q_ok & w_cell;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_field     <= '0;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_count     <= '0;
      r_win       <= 1'b0;
      r_hit_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_d_brick   <= 1'b0;
`ifdef BRICK_HARD_EN
      r_hp        <= '0;
`endif
    end else begin
      r_hit_valid <= bus.q_valid;
      r_hit       <= w_q_ok & w_cell;
      // Non-blocking read: a same-cycle clear is not yet visible here.
      r_d_brick   <= r_field[bus.d_row][bus.d_col];

      if (w_load_start) begin
        r_busy  <= 1'b1;
        r_count <= '0;
        r_ptr   <= '0;
        r_win   <= 1'b0;
      end else if (r_busy) begin
        r_field[r_ptr] <= w_pattern;
`ifdef BRICK_HARD_EN
        r_hp[r_ptr]    <= (r_ptr == '0) ? w_pattern : '0;
`endif
        r_count <= r_count + w_row_pop;
        if (r_ptr == RW'(ROWS - 1)) begin
          r_busy <= 1'b0;
        end else begin
          r_ptr <= r_ptr + RW'(1);
        end
      end else if (w_clear) begin
        r_field[bus.q_row][bus.q_col] <= 1'b0;
        r_count <= r_count - NW'(1);
        if (r_count == NW'(1)) begin
          r_win <= 1'b1;
        end
      end
`ifdef BRICK_HARD_EN
      else if (w_soften) begin
        r_hp[bus.q_row][bus.q_col] <= 1'b0;
      end
`endif
    end
  end

  assign bus.hit_valid = r_hit_valid;
  assign bus.hit       = r_hit;
  assign bus.d_brick   = r_d_brick;
  assign bus.busy      = r_busy;
  assign bus.count     = r_count;
  assign bus.win       = r_win;

endmodule

// File: tb/tb_brick_field.sv
// tb/tb_brick_field.sv - randomized self-checking bench for brick_field (BRICK_HARD_EN aware)
module tb_brick_field;
  import brick_pkg::*;

  localparam int ROWS = DEF_ROWS;
  localparam int COLS = DEF_COLS;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  brick_field_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  brick_field #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model of the field.
  bit m_field [ROWS][COLS];
  bit m_hp    [ROWS][COLS];
  int m_count;
  bit m_win;

  int qr[$];
  int qc[$];

  function automatic bit ref_brick(input int lvl, input int r, input int c);
    int pop;
    pop = (2 + lvl < ROWS) ? 2 + lvl : ROWS;
    if (r >= pop) return 1'b0;
    if (lvl % 2 == 0) return 1'b1;
    return ((r + c) % 2) == 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_field[r][c] = 1'b0;
        m_hp[r][c]    = 1'b0;
      end
    m_count = 0;
    m_win   = 1'b0;
  endtask

  task automatic model_load(input int lvl);
    m_count = 0;
    m_win   = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_field[r][c] = ref_brick(lvl, r, c);
`ifdef BRICK_HARD_EN
        m_hp[r][c] = (r == 0) && m_field[r][c];
`else
        m_hp[r][c] = 1'b0;
`endif
        if (m_field[r][c]) m_count++;
      end
  endtask

  task automatic model_query(input int r, input int c, output bit hit);
    hit = m_field[r][c];
    if (hit) begin
      if (m_hp[r][c]) begin
        m_hp[r][c] = 1'b0;
      end else begin
        m_field[r][c] = 1'b0;
        m_count--;
        if (m_count == 0) m_win = 1'b1;
      end
    end
  endtask

  task automatic do_load(input int lvl);
    int busy_cycles;
    @(negedge clk);
    bus.state = 3'd1;
    bus.level = 3'(lvl);
    @(negedge clk);
    bus.state = 3'd2;
    model_load(lvl);
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < ROWS + 4) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("load_busy_cycles", busy_cycles, ROWS);
    check("load_count", bus.count, m_count);
    check("load_win", bus.win, 0);
  endtask

  task automatic scan(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        bus.d_row = 3'(r);
        bus.d_col = 4'(c);
        @(negedge clk);
        check(tag, bus.d_brick, m_field[r][c]);
      end
  endtask

  task automatic read_cell(input string tag, input int r, input int c, input bit exp);
    @(negedge clk);
    bus.d_row = 3'(r);
    bus.d_col = 4'(c);
    @(negedge clk);
    check(tag, bus.d_brick, exp);
  endtask

  // Back-to-back queries from qr/qc; each response checked the next cycle.
  task automatic run_queries(input string tag);
    bit pend;
    bit pend_hit;
    bit h;
    pend = 1'b0;
    pend_hit = 1'b0;
    for (int i = 0; i <= qr.size(); i++) begin
      @(negedge clk);
      if (pend) begin
        check({tag, "_hv"}, bus.hit_valid, 1);
        check({tag, "_hit"}, bus.hit, pend_hit);
        check({tag, "_count"}, bus.count, m_count);
        check({tag, "_win"}, bus.win, m_win);
      end
      if (i < qr.size()) begin
        bus.q_valid = 1'b1;
        bus.q_row   = 3'(qr[i]);
        bus.q_col   = 4'(qc[i]);
        model_query(qr[i], qc[i], h);
        pend = 1'b1;
        pend_hit = h;
      end else begin
        bus.q_valid = 1'b0;
        pend = 1'b0;
      end
    end
  endtask

  // Random queries plus random display reads every cycle.
  task automatic storm(input int n);
    bit pv, ph, pd, h;
    int r, c, dr, dc;
    pv = 1'b0; ph = 1'b0; pd = 1'b0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("storm_hv", bus.hit_valid, pv);
        if (pv) check("storm_hit", bus.hit, ph);
        check("storm_disp", bus.d_brick, pd);
        check("storm_count", bus.count, m_count);
        check("storm_win", bus.win, m_win);
      end
      if (i < n) begin
        r  = $urandom_range(0, ROWS - 1);
        c  = $urandom_range(0, COLS - 1);
        dr = $urandom_range(0, 1) ? r : $urandom_range(0, ROWS - 1);
        dc = $urandom_range(0, 1) ? c : $urandom_range(0, COLS - 1);
        pv = ($urandom_range(0, 3) != 0);
        bus.q_valid = pv;
        bus.q_row   = 3'(r);
        bus.q_col   = 4'(c);
        bus.d_row   = 3'(dr);
        bus.d_col   = 4'(dc);
        pd = m_field[dr][dc];
        ph = 1'b0;
        if (pv) begin
          model_query(r, c, h);
          ph = h;
        end
      end else begin
        bus.q_valid = 1'b0;
      end
    end
  endtask

  task automatic all_bricks_shuffled();
    int tr, tc, j;
    qr.delete();
    qc.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_field[r][c]) begin
          qr.push_back(r); qc.push_back(c);
          if (m_hp[r][c]) begin
            qr.push_back(r); qc.push_back(c);
          end
        end
    for (int i = qr.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tr = qr[i]; qr[i] = qr[j]; qr[j] = tr;
      tc = qc[i]; qc[i] = qc[j]; qc[j] = tc;
    end
  endtask

  initial begin
    bit h;
    rst         = 1'b0;
    bus.state   = 3'd2;
    bus.level   = 3'd0;
    bus.q_valid = 1'b0;
    bus.q_row   = '0;
    bus.q_col   = '0;
    bus.d_row   = '0;
    bus.d_col   = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.count, 0);
    check("rst_win", bus.win, 0);
    check("rst_hv", bus.hit_valid, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_disp", bus.d_brick, 0);
    rst = 1'b1;

    // Level 0: rows 0-1 full.
    do_load(0);
    check("lvl0_count", bus.count, 32);
    scan("lvl0_scan");

    // Level 1: checkerboard over 3 rows.
    do_load(1);
    check("lvl1_count", bus.count, 24);
    read_cell("lvl1_cell00", 0, 0, 1'b1);
    read_cell("lvl1_cell01", 0, 1, 1'b0);
    scan("lvl1_scan");

    do_load(7);
    check("lvl7_count", bus.count, 64);

    // Random levels.
    for (int k = 0; k < 3; k++) begin
      do_load($urandom_range(0, 7));
      scan("rand_scan");
    end

    // Single hit then repeat on the same cell.
    do_load(0);
    qr = '{0, 0};
    qc = '{0, 0};
    run_queries("repeat");
`ifndef BRICK_HARD_EN
    check("repeat_count31", bus.count, 31);
`else
    check("hard_count31", bus.count, 31);
    do_load(0);
    qr = '{0, 0};
    qc = '{3, 3};
    run_queries("hard03");
`endif

    // Clear every brick back-to-back; win on the last response.
    do_load(0);
    all_bricks_shuffled();
    run_queries("clear_all");
    check("clear_all_win", bus.win, 1);
    check("clear_all_count0", bus.count, 0);
    do_load(0);
    check("reload_win", bus.win, 0);
    check("reload_count", bus.count, 32);

    // Random query storm on random levels.
    for (int k = 0; k < 2; k++) begin
      do_load($urandom_range(0, 7));
      storm(200);
    end

    // Query while busy is ignored.
    @(negedge clk);
    bus.state = 3'd1;
    bus.level = 3'd0;
    @(negedge clk);
    bus.state   = 3'd2;
    bus.q_valid = 1'b1;
    bus.q_row   = 3'd0;
    bus.q_col   = 4'd0;
    model_load(0);
    @(negedge clk);
    bus.q_valid = 1'b0;
    check("busy_q_hv", bus.hit_valid, 1);
    check("busy_q_hit", bus.hit, 0);
    for (int i = 0; i < ROWS + 4 && bus.busy === 1'b1; i++) @(negedge clk);
    check("busy_q_done", bus.busy, 0);
    check("busy_q_count", bus.count, 32);
    read_cell("busy_q_cell", 0, 0, 1'b1);

    // Reset mid-load.
    bus.d_row = 3'd0;
    bus.d_col = 4'd0;
    @(negedge clk);
    bus.state = 3'd1;
    bus.level = 3'd5;
    @(negedge clk);
    bus.state   = 3'd2;
    bus.q_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_win", bus.win, 0);
    check("mid_rst_hv", bus.hit_valid, 0);
    check("mid_rst_hit", bus.hit, 0);
    check("mid_rst_disp", bus.d_brick, 0);
    bus.q_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_count", bus.count, 0);
    read_cell("post_rst_cell", 0, 0, 1'b0);
    qr = '{1};
    qc = '{2};
    run_queries("post_rst_q");
    h = bus.win;
    check("post_rst_nowin", h, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/brick_field.md
# brick_field

Brick-map store for the brick game. Sits downstream of the game state manager: it loads a level-dependent brick pattern when the manager enters the level-init state, answers ball-collision queries from the ball engine by clearing struck bricks, and reports `win` back to the manager when the last brick is gone. A second, read-only port serves the display renderer.

## Interface
- `ROWS`, default 8: brick rows.
- `COLS`, default 16: brick columns.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `state`  in  3  game state from the state manager: 0 load, 1 init, 2 wait, 3 fly.
- `level`  in  3  current level.
- `q_valid`  in  1  collision query strobe from the ball engine.
- `q_row`  in  $clog2(ROWS)  query row.
- `q_col`  in  $clog2(COLS)  query column.
- `hit_valid`  out  1  query response strobe.
- `hit`  out  1  queried cell held a brick; the ball must reflect.
- `d_row`  in  $clog2(ROWS)  display read row.
- `d_col`  in  $clog2(COLS)  display read column.
- `d_brick`  out  1  display read data.
- `busy`  out  1  pattern load in progress.
- `count`  out  $clog2(ROWS*COLS+1)  bricks remaining.
- `win`  out  1  field cleared.

## Operation
- Reset values: all brick bits 0, `count` 0, `busy` 0, `win` 0, `hit_valid` 0, `hit` 0, `d_brick` 0, load row pointer 0.
- **Load start:** any cycle with `state==1` starts a load.
  - Clears `win`, sets `busy`, zeroes `count` and row pointer 0.
  - The load is restarted if one is already running.
- **Loading:**
  - Writes one row per cycle, rows 0..ROWS-1, taking ROWS cycles.
  - `count` accumulates the popcount of each written row.
  - `busy` falls after the last row is written.
- **Pattern for row r, column c:**
  - Populated rows: r < min(2+level, ROWS).
  - Even level: every cell of a populated row is a brick.
  - Odd level: a cell of a populated row is a brick only when (r+c) is even.
  - Unpopulated rows are empty.
- **Query behaviour:**
  - A query is accepted in any state and always produces `hit_valid` one cycle later.
  - `busy`=1: response `hit`=0 and no change to the field.
  - Brick present: `hit`=1, the brick is cleared, `count` is decremented.
  - Brick absent: `hit`=0.
- **Win:** set on the cycle `count` goes 1→0 from a query. It stays high until the next load start. It never sets as a result of a load that yields 0 bricks.
- **Display port:** registered read of the brick bit. A query clearing the same cell in the same cycle returns the pre-clear value.
- `state` values other than 1 do not affect this block.

## Timing
- Query latency: `q_valid` at edge N → `hit_valid`/`hit` valid after edge N+1 for one cycle. The cleared bit and the new `count` are visible from the same edge.
- Back-to-back queries are accepted every cycle with no stall. A repeat query to the same cell on cycle N+1 sees the cleared bit.
- Load: `state==1` sampled at edge N → `busy`=1 after N. Row k is written at edge N+1+k. `busy`=0 after edge N+ROWS, with the final `count` valid at that point.
- The state manager sits in state 1 for one cycle, then state 2. The load completes during the wait state, before any launch.
- Display read latency: 1 cycle.
- Reset asserted mid-load aborts immediately to reset values.

## Configuration
- `BRICK_HARD_EN` defined:
  - Row 0 bricks load with two hit points; a per-cell hit-point bit is stored.
  - First hit: `hit`=1, the hit-point bit clears, the brick remains and `count` is unchanged.
  - Second hit: the brick clears and `count` decrements.
  - `d_brick` reflects presence only.
- Without the macro: every brick clears on its first hit and there is no hit-point storage.

## Structure
- Package `brick_pkg`:
  - `ROWS`, `COLS` defaults.
  - State encodings `ST_LOAD`=0, `ST_INIT`=1, `ST_WAIT`=2, `ST_FLY`=3.
  - Count width constant.
  - Row-pattern function prototype constants.
- Sub-module `brick_pattern`: combinational; takes `level` and a row index, produces the COLS-bit row pattern. It is instantiated once and indexed by the load pointer.

## Test plan
- Reset, then `state`=1 at level 0 → `busy` high 8 cycles; `count`=32; rows 0–1 full, rest empty via the display port.
- Load at level 1 → `count`=24, cell (0,0)=1, (0,1)=0. Load at level 7 → `count`=64.
- Level 0 loaded; query (0,0) → `hit_valid`=1, `hit`=1, `count`=31. Repeat the query next cycle → `hit`=0, `count` stays 31.
- Level 0 loaded; 32 back-to-back queries over all bricks → `win` rises on the response to the 32nd query. Then `state`=1 → `win` clears, `count` reloads to 32.
- Query during `busy` → `hit_valid`=1, `hit`=0, loaded `count` unaffected. Reset asserted mid-load → all outputs 0.
- With `BRICK_HARD_EN`: query (0,3) twice → `hit`=1 both times, `count` 32→32→31.
